// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption engines and their output collector.
//   D_WIDTH          : character width
//   char_t           : one character
//   CAESAR/SCYTALE/ZIGZAG : engine indices on the collector's select input
//   state_t          : collector FSM states (IDLE waits for a message, ACTIVE streams it)
package decryption_pkg;

  localparam int D_WIDTH = 8;

  typedef logic [D_WIDTH-1:0] char_t;

  localparam logic [1:0] CAESAR  = 2'd0;
  localparam logic [1:0] SCYTALE = 2'd1;
  localparam logic [1:0] ZIGZAG  = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and count)
//   push/wdata : write request; ignored when full unless a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   rdata      : entry at the head (valid while empty = 0)
//   full/empty : occupancy flags
//   count      : occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decryption_output_collector.sv
// Collects the character stream of one decryption engine, tags the final
// character of each message, and buffers the result for a ready/valid consumer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   select              : engine index, sampled only while IDLE
//   data0..2_i/valid0..2_i : engine outputs (caesar, scytale, zigzag); never stalled
//   ready_i             : consumer accepts data_o this cycle
//   data_o/last_o       : FIFO head; hold their last value while the FIFO is empty
//   valid_o             : FIFO non-empty
//   busy_o              : message in progress or FIFO non-empty
//   overflow_o          : sticky, a character was dropped on a full FIFO
module decryption_output_collector
  import decryption_pkg::*;
#(
  parameter int D_WIDTH     = decryption_pkg::D_WIDTH,
  parameter int FIFO_DEPTH  = 8,
  parameter int NOF_ENGINES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         select,
  input  logic [D_WIDTH-1:0] data0_i,
  input  logic               valid0_i,
  input  logic [D_WIDTH-1:0] data1_i,
  input  logic               valid1_i,
  input  logic [D_WIDTH-1:0] data2_i,
  input  logic               valid2_i,
  input  logic               ready_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic               last_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               overflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             next_state;
  logic [1:0]         sel_q;
  logic [1:0]         idx;
  logic [D_WIDTH-1:0] hold;
  logic [D_WIDTH-1:0] mux_data;
  logic               mux_valid;
  logic               sel_ok;
  logic               fifo_push;
  logic               push_last;
  logic               load_hold;
  logic               latch_sel;
  logic [D_WIDTH:0]   wdata;
  logic [D_WIDTH:0]   rdata;
  logic [D_WIDTH:0]   out_q;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;

  // While a message is streaming, only the latched engine is observed.
  assign idx    = (state == IDLE) ? select : sel_q;
  assign sel_ok = ({30'd0, select} < 32'(NOF_ENGINES));

  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    case (idx)
      CAESAR:  begin mux_data = data0_i; mux_valid = valid0_i; end
      SCYTALE: begin mux_data = data1_i; mux_valid = valid1_i; end
      ZIGZAG:  begin mux_data = data2_i; mux_valid = valid2_i; end
      default: begin mux_data = '0;      mux_valid = 1'b0;     end
    endcase
  end

  // A character sits in the hold register for one cycle so that its last
  // flag is known (the engine's valid dropping) by the time it is pushed.
  always_comb begin
    next_state = state;
    fifo_push  = 1'b0;
    push_last  = 1'b0;
    load_hold  = 1'b0;
    latch_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok && mux_valid) begin
          latch_sel  = 1'b1;
          load_hold  = 1'b1;
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        fifo_push = 1'b1;
        if (mux_valid) begin
          load_hold = 1'b1;
        end else begin
          push_last  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      overflow_o <= 1'b0;
      out_q      <= '0;
    end else begin
      state <= next_state;
      if (latch_sel) sel_q <= select;
      // A full FIFO only drops the entry when nothing is popped alongside.
      if (fifo_push && full && !ready_i) overflow_o <= 1'b1;
      if (ready_i && !empty) out_q <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (load_hold) hold <= mux_data;
  end

  assign wdata = {push_last, hold};

  sync_fifo #(
    .WIDTH (D_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (ready_i),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // When empty, present the most recently popped entry so data_o holds.
  assign data_o  = empty ? out_q[D_WIDTH-1:0] : rdata[D_WIDTH-1:0];
  assign last_o  = empty ? out_q[D_WIDTH]     : rdata[D_WIDTH];
  assign valid_o = !empty;
  assign busy_o  = (state == ACTIVE) || (count != '0);

endmodule

// File: tb/tb_decryption_output_collector.sv
module tb_decryption_output_collector;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic       last;
    logic [7:0] d;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] sel;
  logic [7:0] d [3];
  logic       v [3];
  logic       rdy;
  logic [7:0] data_o;
  logic       last_o;
  logic       valid_o;
  logic       busy_o;
  logic       overflow_o;

  int total;
  int bad;

  // Reference model: the FIFO as a queue of entries, plus the message in flight.
  entry_t     mq[$];
  entry_t     popped[$];
  entry_t     m_out;
  bit         m_ovf;
  bit         m_in_msg;
  int         m_sel;
  logic [7:0] m_pend;

  decryption_output_collector #(
    .D_WIDTH     (8),
    .FIFO_DEPTH  (DEPTH),
    .NOF_ENGINES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (sel),
    .data0_i    (d[0]),
    .valid0_i   (v[0]),
    .data1_i    (d[1]),
    .valid1_i   (v[1]),
    .data2_i    (d[2]),
    .valid2_i   (v[2]),
    .ready_i    (rdy),
    .data_o     (data_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out    = '0;
    m_ovf    = 1'b0;
    m_in_msg = 1'b0;
    m_sel    = 0;
  endtask

  task automatic check_outputs(input string tag);
    entry_t e;
    e = (mq.size() > 0) ? mq[0] : m_out;
    check({tag, "_valid"}, valid_o, mq.size() > 0);
    check({tag, "_data"}, data_o, e.d);
    check({tag, "_last"}, last_o, e.last);
    check({tag, "_busy"}, busy_o, m_in_msg || (mq.size() > 0));
    check({tag, "_ovf"}, overflow_o, m_ovf);
  endtask

  // One clock: advance the model on the sampled inputs, then compare.
  task automatic step(input string tag);
    entry_t e;
    int     sz;
    bit     pop;
    logic   vs;
    @(posedge clk);
    if (rst_n) begin
      sz  = mq.size();
      pop = rdy && (sz > 0);
      if (pop) begin
        e = mq.pop_front();
        m_out = e;
        popped.push_back(e);
      end
      if (m_in_msg) begin
        vs = v[m_sel];
        e.last = !vs;
        e.d    = m_pend;
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else mq.push_back(e);
        if (vs) m_pend = d[m_sel];
        else m_in_msg = 1'b0;
      end else if (int'(sel) < 3 && v[sel]) begin
        m_in_msg = 1'b1;
        m_sel    = int'(sel);
        m_pend   = d[sel];
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      d[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic drive_msg(input int eng, input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      d[eng] = s[i];
      v[eng] = 1'b1;
      step(tag);
    end
    v[eng] = 1'b0;
  endtask

  // Compare the popped stream to s; last_idx is the entry expected to carry last (-1: none).
  task automatic check_popped(input string tag, input string s, input int last_idx);
    check({tag, "_n"}, popped.size(), s.len());
    for (int i = 0; i < s.len() && i < popped.size(); i++) begin
      check({tag, "_chr"}, popped[i].d, s[i]);
      check({tag, "_lst"}, popped[i].last, (i == last_idx));
    end
    popped.delete();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    sel   = 2'd0;
    rdy   = 1'b0;
    idle_inputs();
    model_reset();
    #2;

    // Test 1: HELLO on scytale, no back-pressure, latency check.
    do_reset();
    sel = 2'd1;
    rdy = 1'b1;
    d[1] = "H";
    v[1] = 1'b1;
    step("t1");
    check("t1_lat_capture", valid_o, 1'b0);
    d[1] = "E";
    step("t1");
    check("t1_lat_push", valid_o, 1'b1);
    check("t1_first", data_o, "H");
    drive_msg(1, "LLO", "t1");
    for (int i = 0; i < 6; i++) step("t1_drain");
    check("t1_busy_end", busy_o, 1'b0);
    check_popped("t1", "HELLO", 4);

    // Test 2: select changes mid-message; engine 2 active concurrently.
    sel = 2'd0;
    d[0] = "A";
    v[0] = 1'b1;
    step("t2");
    sel  = 2'd2;
    d[2] = "x";
    v[2] = 1'b1;
    d[0] = "B";
    step("t2");
    d[0] = "C";
    d[2] = "y";
    step("t2");
    v[0] = 1'b0;
    d[2] = "z";
    step("t2");
    v[2] = 1'b0;
    for (int i = 0; i < 6; i++) step("t2_drain");
    check_popped("t2", "ABC", 2);

    // Test 3: back-pressure with overflow on a 12-character message.
    do_reset();
    popped.delete();
    rdy = 1'b0;
    sel = 2'd0;
    drive_msg(0, "ABCDEFGHIJKL", "t3");
    for (int i = 0; i < 3; i++) step("t3_hold");
    check("t3_ovf", overflow_o, 1'b1);
    check("t3_head", data_o, "A");
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) step("t3_drain");
    check("t3_ovf_sticky", overflow_o, 1'b1);
    check_popped("t3", "ABCDEFGH", -1);

    // Test 4: full FIFO, final push coincides with a pop.
    do_reset();
    popped.delete();
    rdy = 1'b0;
    sel = 2'd2;
    drive_msg(2, "abcdefghi", "t4");
    rdy = 1'b1;
    step("t4_pushpop");
    check("t4_no_ovf", overflow_o, 1'b0);
    for (int i = 0; i < 10; i++) step("t4_drain");
    check_popped("t4", "abcdefghi", 8);

    // Test 5: invalid select ignored, then single-character message.
    do_reset();
    popped.delete();
    rdy  = 1'b1;
    sel  = 2'd3;
    d[0] = "Q";
    v[0] = 1'b1;
    for (int i = 0; i < 3; i++) step("t5_inv");
    check("t5_inv_busy", busy_o, 1'b0);
    sel = 2'd0;
    drive_msg(0, "Z", "t5");
    for (int i = 0; i < 4; i++) step("t5_drain");
    check_popped("t5", "Z", 0);

    // Test 6: asynchronous reset in the middle of a message.
    rdy = 1'b0;
    sel = 2'd1;
    drive_msg(1, "RST", "t6");
    d[1] = "U";
    v[1] = 1'b1;
    step("t6");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    popped.delete();
    check("t6_valid_async", valid_o, 1'b0);
    check("t6_busy_async", busy_o, 1'b0);
    check("t6_ovf_async", overflow_o, 1'b0);
    step("t6_inreset");
    #2;
    rst_n = 1'b1;
    v[1] = 1'b0;
    step("t6_after");
    check("t6_empty", valid_o, 1'b0);
    rdy = 1'b1;
    drive_msg(1, "OK", "t6b");
    for (int i = 0; i < 4; i++) step("t6_drain");
    check_popped("t6", "OK", 1);

    // Randomized traffic against the model.
    do_reset();
    popped.delete();
    for (int c = 0; c < 400; c++) begin
      sel = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 99) < 55);
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 99) < 70);
        d[i] = 8'($urandom);
      end
      step("rnd");
    end
    idle_inputs();
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) step("rnd_drain");
    check("rnd_empty", valid_o, 1'b0);
    check("rnd_idle", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
